addsub_serial: RTL and testbench

Parametrised, digit-serial two's-complement adder/subtractor with valid/ready handshakes on input and output. It processes `DIGIT` bits per clock, LSB first, through a ripple carry chain, holding the carry in a register between digits. Subtraction is done by inverting operand b and injecting a carry-in of 1. It is the width-scalable, area-trimmed successor to the combinational 8-bit add/sub datapath. It adds overflow and zero flags and supports back-pressure, and it sits between operand-producing logic and result consumers.

---
 rtl/addsub_pkg.sv | 19 +
 rtl/addsub_digit.sv | 26 ++
 rtl/addsub_serial.sv | 114 +++++++++++
 tb/tb_addsub_serial.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

  // Wide enough to hold N itself, so the counter never wraps mid-operation.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple adder; exposes the carry into its top bit for overflow.
module addsub_digit #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             ctop,
  output logic             cout
);

  always_comb begin
    logic [DIGIT:0] carry;
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end
    ctop = carry[DIGIT-1];
    cout = carry[DIGIT];
  end

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement add/sub, LSB first, with valid/ready on both sides.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = num_digits(WIDTH, DIGIT);
  localparam int CW = cnt_width(N);

  generate
    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_badParams
      $error("addsub_serial: illegal WIDTH/DIGIT combination");
    end
  endgenerate

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_sub;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic [DIGIT-1:0] w_sum;
  logic             w_ctop;
  logic             w_cout;
  logic [WIDTH-1:0] w_sNext;
  logic             w_last;

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (r_a[DIGIT-1:0]),
    .b    (r_b[DIGIT-1:0]),
    .cin  (r_carry),
    .sum  (w_sum),
    .ctop (w_ctop),
    .cout (w_cout)
  );

  // New digit enters at the top so after N shifts the result is right-aligned.
  assign w_sNext = (r_s >> DIGIT) | (WIDTH'(w_sum) << (WIDTH - DIGIT));
  assign w_last  = (r_cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b ^ {WIDTH{sub}};
            r_sub   <= sub;
            r_carry <= sub;
            r_cnt   <= '0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_s     <= w_sNext;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_cout  <= r_sub ^ w_cout;
            r_ovf   <= w_ctop ^ w_cout;
            r_zero  <= (w_sNext == '0);
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign s         = r_s;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_addsub_serial.sv
// Directed table plus corner sequences for 16/4, and a randomised model check for 8/8.
module tb_addsub_serial;

  logic clk;
  logic rst;

  logic        v16In, r16In, sub16, v16Out, r16Out, c16, o16, z16;
  logic [15:0] a16, b16, s16;

  logic        v8In, r8In, sub8, v8Out, r8Out, c8, o8, z8;
  logic [7:0]  a8, b8, s8;

  int checks;
  int errors;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vecs[8];

  addsub_serial #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16In), .in_ready(r16In), .a(a16), .b(b16),
    .sub(sub16), .out_valid(v16Out), .out_ready(r16Out), .s(s16), .cout(c16),
    .ovf(o16), .zero(z16)
  );

  addsub_serial #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8In), .in_ready(r8In), .a(a8), .b(b8),
    .sub(sub8), .out_valid(v8Out), .out_ready(r8Out), .s(s8), .cout(c8),
    .ovf(o8), .zero(z8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one 16-bit op from IDLE through the output handshake; all activity at negedges.
  task automatic applyStimulus(input string name, input vec_t v);
    int lat;
    checkOutput({name, " in_ready before"}, 32'(r16In), 32'd1);
    a16 = v.a; b16 = v.b; sub16 = v.sub; v16In = 1'b1;
    @(negedge clk);
    v16In = 1'b0;
    a16 = ~v.a; b16 = ~v.b; sub16 = ~v.sub;
    lat = 0;
    while (!v16Out && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({name, " latency"}, 32'(lat), 32'd4);
    checkOutput({name, " s"},    32'(s16), 32'(v.s));
    checkOutput({name, " cout"}, 32'(c16), 32'(v.cout));
    checkOutput({name, " ovf"},  32'(o16), 32'(v.ovf));
    checkOutput({name, " zero"}, 32'(z16), 32'(v.zero));
    r16Out = 1'b1;
    @(negedge clk);
    r16Out = 1'b0;
    checkOutput({name, " idle after"}, 32'(v16Out), 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1;
    v16In = 0; a16 = 0; b16 = 0; sub16 = 0; r16Out = 0;
    v8In = 0; a8 = 0; b8 = 0; sub8 = 0; r8Out = 0;

    vecs[0] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset in_ready", 32'(r16In), 32'd1);
    checkOutput("reset out_valid", 32'(v16Out), 32'd0);
    checkOutput("reset outputs", {13'd0, z16, o16, c16, s16}, 32'd0);

    // out_ready while idle must not produce anything
    r16Out = 1'b1;
    @(negedge clk);
    r16Out = 1'b0;
    checkOutput("idle out_ready", 32'(v16Out), 32'd0);

    for (int i = 0; i < 8; i++) applyStimulus($sformatf("vec%0d", i), vecs[i]);

    // Back-pressure: result frozen, new request refused while DONE
    a16 = 16'h1111; b16 = 16'h2222; sub16 = 1'b0; v16In = 1'b1;
    @(negedge clk);
    v16In = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("bp out_valid", 32'(v16Out), 32'd1);
    a16 = 16'h0F0F; b16 = 16'h0101; sub16 = 1'b1; v16In = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp s stable", 32'(s16), 32'h3333);
      checkOutput("bp flags stable", {29'd0, z16, o16, c16}, 32'd0);
      checkOutput("bp in_ready", 32'(r16In), 32'd0);
      checkOutput("bp out_valid held", 32'(v16Out), 32'd1);
    end
    v16In = 1'b0;
    r16Out = 1'b1;
    @(negedge clk);
    r16Out = 1'b0;
    checkOutput("bp idle in_ready", 32'(r16In), 32'd1);
    checkOutput("bp idle out_valid", 32'(v16Out), 32'd0);

    // Abort after two digits
    a16 = 16'hFFFF; b16 = 16'h0003; sub16 = 1'b0; v16In = 1'b1;
    @(negedge clk);
    v16In = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort out_valid", 32'(v16Out), 32'd0);
    checkOutput("abort in_ready", 32'(r16In), 32'd1);
    checkOutput("abort outputs", {13'd0, z16, o16, c16, s16}, 32'd0);
    repeat (6) @(negedge clk);
    checkOutput("abort no pulse", 32'(v16Out), 32'd0);
    applyStimulus("after abort", vecs[7]);

    // N=1 instance against an arithmetic reference
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ea, eb, es;
      logic       esub, ec, eo;
      logic [8:0] full;
      int         lat;
      ea = 8'($urandom); eb = 8'($urandom); esub = 1'($urandom);
      if (i == 0) begin ea = 8'h80; eb = 8'h01; esub = 1'b1; end
      if (i == 1) begin ea = 8'h7F; eb = 8'h7F; esub = 1'b0; end
      if (esub) full = {1'b0, ea} - {1'b0, eb};
      else      full = {1'b0, ea} + {1'b0, eb};
      es = full[7:0];
      ec = full[8];
      if (esub) eo = (ea[7] != eb[7]) && (es[7] != ea[7]);
      else      eo = (ea[7] == eb[7]) && (es[7] != ea[7]);
      a8 = ea; b8 = eb; sub8 = esub; v8In = 1'b1;
      @(negedge clk);
      v8In = 1'b0;
      lat = 0;
      while (!v8Out && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      checkOutput("n1 latency", 32'(lat), 32'd1);
      checkOutput("n1 s", 32'(s8), 32'(es));
      checkOutput("n1 cout", 32'(c8), 32'(ec));
      checkOutput("n1 ovf", 32'(o8), 32'(eo));
      checkOutput("n1 zero", 32'(z8), 32'(es == 8'd0));
      r8Out = 1'b1;
      @(negedge clk);
      r8Out = 1'b0;
      checkOutput("n1 idle", 32'(r8In), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
